// File: rtl/flash_fetch_unit_pkg.sv
// flash_fetch_unit_pkg
//   Shared definitions for the flash fetch path. The state encodings live here
//   next to the control unit's state defines so both ends agree on them.
//   Contents:
//     ff_state_t   - fetch FSM state encoding (INIT / IDLE / ACCESS)
//     ff_sel_half  - selects the Thumb halfword of a 32-bit flash word
package flash_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FF_INIT   = 2'b00,
    FF_IDLE   = 2'b01,
    FF_ACCESS = 2'b10
  } ff_state_t;

  // Little-endian halfword select: byte-address bit 1 picks the upper half.
  function automatic logic [15:0] ff_sel_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// fetch_line_buffer
//   One-word line buffer for the flash fetch unit. Holds the last flash word
//   read, its word tag and a valid bit, and answers hit/halfword lookups
//   combinationally so a hit can be returned on the cycle after the strobe.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (invalidates the line)
//   load         write load_word/load_tag into the line and mark it valid
//   load_tag     word tag (byte address bits [ADDR_W-1:2]) of load_word
//   load_word    32-bit flash word to store
//   lookup_tag   word tag of the current request
//   lookup_hi    byte-address bit 1 of the current request
//   hit          line valid and tag matches lookup_tag
//   half         halfword of the stored word selected by lookup_hi
module fetch_line_buffer
  import flash_fetch_unit_pkg::*;
#(
  parameter int TAG_W = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TAG_W-1:0] load_tag,
  input  logic [31:0]      load_word,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             lookup_hi,
  output logic             hit,
  output logic [15:0]      half
);

  logic [31:0]      word_q;
  logic [TAG_W-1:0] tag_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= load_word;
      tag_q   <= load_tag;
      valid_q <= 1'b1;
    end
  end

  assign hit  = valid_q && (lookup_tag == tag_q);
  assign half = ff_sel_half(word_q, lookup_hi);

endmodule

// File: rtl/flash_fetch_unit.sv
// flash_fetch_unit
//   Flash-side responder for the control unit's instruction fetch. A one-cycle
//   ld_flash strobe requests the Thumb halfword at addr. Hits in the one-word
//   line buffer return on the next cycle; misses read the flash word with
//   WAIT_STATES wait cycles and return WAIT_STATES+1 cycles after the strobe.
//   After reset the unit runs an INIT window with flash_busy high (the control
//   unit leaves its startup state on that rising edge) and preloads the line
//   buffer with the word at RESET_ADDR.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   ld_flash     read request strobe, sampled at posedge
//   addr         byte address of the halfword; bit 0 ignored
//   flash_busy   high while an access or the init window is in progress
//   instr        fetched halfword; holds between fetches
//   instr_valid  one-cycle pulse when instr is updated
//   mem_rd       read enable to the flash array
//   mem_addr     word-aligned flash address; holds while mem_rd is low
//   mem_rdata    flash data, valid once mem_rd has been high WAIT_STATES cycles
module flash_fetch_unit
  import flash_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_STATES = 2,
  parameter int                INIT_CYCLES = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_flash,
  input  logic [ADDR_W-1:0] addr,
  output logic              flash_busy,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int TAG_W    = ADDR_W - 2;
  // The init window must also cover a full flash read of RESET_ADDR.
  localparam int INIT_LEN = (INIT_CYCLES > WAIT_STATES) ? INIT_CYCLES : WAIT_STATES;
  localparam int WCNT_W   = $clog2(WAIT_STATES + 1);
  localparam int ICNT_W   = $clog2(INIT_LEN + 1);

  ff_state_t          state_q, state_d;
  logic [WCNT_W-1:0]  wait_q, wait_d;
  logic [ICNT_W-1:0]  init_q, init_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic               req_hi_q, req_hi_d;
  logic               busy_d, rd_d, valid_d;
  logic [ADDR_W-1:0]  maddr_d;
  logic [15:0]        instr_d;

  logic               buf_load;
  logic [TAG_W-1:0]   buf_load_tag;
  logic               buf_hit;
  logic [15:0]        buf_half;

  logic               unused_addr_bit;
  assign unused_addr_bit = addr[0];

  fetch_line_buffer #(
    .TAG_W (TAG_W)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_tag   (buf_load_tag),
    .load_word  (mem_rdata),
    .lookup_tag (addr[ADDR_W-1:2]),
    .lookup_hi  (addr[1]),
    .hit        (buf_hit),
    .half       (buf_half)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FF_INIT;
      wait_q      <= '0;
      init_q      <= '0;
      req_tag_q   <= '0;
      req_hi_q    <= 1'b0;
      flash_busy  <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      init_q      <= init_d;
      req_tag_q   <= req_tag_d;
      req_hi_q    <= req_hi_d;
      flash_busy  <= busy_d;
      mem_rd      <= rd_d;
      mem_addr    <= maddr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
    end
  end

  // All outputs are registered: this block computes their next values.
  // Strobes that arrive outside IDLE are dropped, never queued.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    init_d       = init_q;
    req_tag_d    = req_tag_q;
    req_hi_d     = req_hi_q;
    busy_d       = flash_busy;
    rd_d         = mem_rd;
    maddr_d      = mem_addr;
    instr_d      = instr;
    valid_d      = 1'b0;
    buf_load     = 1'b0;
    buf_load_tag = req_tag_q;

    case (state_q)
      FF_INIT: begin
        // init_q==0 is the reset cycle with flash_busy still low, so the
        // first edge after release produces a clean 0->1 on flash_busy.
        if (init_q == ICNT_W'(INIT_LEN)) begin
          buf_load     = 1'b1;
          buf_load_tag = RESET_ADDR[ADDR_W-1:2];
          busy_d       = 1'b0;
          rd_d         = 1'b0;
          init_d       = '0;
          wait_d       = '0;
          state_d      = FF_IDLE;
        end else begin
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          maddr_d = {RESET_ADDR[ADDR_W-1:2], 2'b00};
          init_d  = init_q + 1'b1;
        end
      end

      FF_IDLE: begin
        busy_d = 1'b0;
        rd_d   = 1'b0;
        if (ld_flash) begin
          if (buf_hit) begin
            instr_d = buf_half;
            valid_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            rd_d      = 1'b1;
            maddr_d   = {addr[ADDR_W-1:2], 2'b00};
            req_tag_d = addr[ADDR_W-1:2];
            req_hi_d  = addr[1];
            wait_d    = WCNT_W'(1);
            state_d   = FF_ACCESS;
          end
        end
      end

      FF_ACCESS: begin
        // wait_q counts cycles mem_rd has been high; at the limit the flash
        // data is valid and is returned directly while the line is refilled.
        if (wait_q == WCNT_W'(WAIT_STATES)) begin
          buf_load = 1'b1;
          instr_d  = ff_sel_half(mem_rdata, req_hi_q);
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          rd_d     = 1'b0;
          wait_d   = '0;
          state_d  = FF_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        init_d  = '0;
        wait_d  = '0;
        state_d = FF_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_fetch_unit.sv
// tb_flash_fetch_unit
//   Scoreboard bench for flash_fetch_unit. Three instances (WAIT_STATES 2, 1
//   and 3) share one stimulus stream. A transaction-level model per instance
//   decides which strobes are accepted, whether they hit, and when the
//   halfword must appear; expectations go into per-instance queues that an
//   independent monitor pops whenever instr_valid is seen.
module tb_flash_fetch_unit;

  localparam int N_INST      = 3;
  localparam int INIT_CYCLES = 4;

  typedef struct {
    int unsigned edge_no;
    logic [15:0] half;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld_flash;
  logic [31:0] addr;

  logic        flash_busy  [N_INST];
  logic [15:0] instr       [N_INST];
  logic        instr_valid [N_INST];
  logic        mem_rd      [N_INST];
  logic [31:0] mem_addr    [N_INST];

  logic [31:0] mem [256];
  int unsigned cyc;
  int          checks;
  int          errors;

  exp_t        exp_q     [N_INST][$];
  int unsigned free_at   [N_INST];
  int unsigned win_lo    [N_INST];
  int unsigned win_hi    [N_INST];
  logic [31:0] win_addr  [N_INST];
  logic        buf_valid [N_INST];
  logic [29:0] buf_tag   [N_INST];
  logic [31:0] buf_word  [N_INST];
  logic [15:0] exp_instr [N_INST];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic int init_len(input int g);
    return (INIT_CYCLES > ws_of(g)) ? INIT_CYCLES : ws_of(g);
  endfunction

  function automatic logic [15:0] half_of(input logic [31:0] w, input logic [31:0] a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int WS = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic [31:0] mem_rdata_g;
    int unsigned rd_age;

    // Flash array model: data only valid once mem_rd has been high WS cycles.
    always @(posedge clk) rd_age <= mem_rd[g] ? rd_age + 1 : 0;
    assign mem_rdata_g = (mem_rd[g] && (rd_age + 1 >= WS)) ? mem[mem_addr[g][9:2]] : 32'hDEAD_DEAD;

    flash_fetch_unit #(
      .ADDR_W      (32),
      .WAIT_STATES (WS),
      .INIT_CYCLES (INIT_CYCLES),
      .RESET_ADDR  (32'h0)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_flash    (ld_flash),
      .addr        (addr),
      .flash_busy  (flash_busy[g]),
      .instr       (instr[g]),
      .instr_valid (instr_valid[g]),
      .mem_rd      (mem_rd[g]),
      .mem_addr    (mem_addr[g]),
      .mem_rdata   (mem_rdata_g)
    );
  end

  task automatic check_output(input string name, input int g, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, g, cyc, act, exp);
    end
  endtask

  // Model of one request reaching instance g at edge n.
  task automatic model_request(input int g, input int unsigned n, input logic [31:0] a);
    exp_t e;
    if (n < free_at[g]) return;
    if (buf_valid[g] && buf_tag[g] == a[31:2]) begin
      e.edge_no = n;
      e.half    = half_of(buf_word[g], a);
      free_at[g] = n + 1;
    end else begin
      buf_valid[g] = 1'b1;
      buf_tag[g]   = a[31:2];
      buf_word[g]  = mem[a[9:2]];
      e.edge_no    = n + ws_of(g);
      e.half       = half_of(buf_word[g], a);
      win_lo[g]    = n;
      win_hi[g]    = n + ws_of(g);
      win_addr[g]  = {a[31:2], 2'b00};
      free_at[g]   = n + ws_of(g) + 1;
    end
    exp_q[g].push_back(e);
  endtask

  // Drives one cycle of stimulus from a negedge; sampled at the next posedge.
  task automatic apply_stimulus(input logic ld, input logic [31:0] a);
    int unsigned n;
    n = cyc + 1;
    ld_flash = ld;
    addr     = a;
    if (ld) begin
      for (int g = 0; g < N_INST; g++) model_request(g, n, a);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    int unsigned n;
    rst      = 1'b1;
    ld_flash = 1'b0;
    for (int g = 0; g < N_INST; g++) begin
      exp_q[g].delete();
      win_lo[g]    = 0;
      win_hi[g]    = 0;
      win_addr[g]  = 32'h0;
      buf_valid[g] = 1'b0;
      free_at[g]   = 32'hFFFF_FFFF;
    end
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    n = cyc + 1;
    for (int g = 0; g < N_INST; g++) begin
      win_lo[g]    = n;
      win_hi[g]    = n + init_len(g);
      win_addr[g]  = 32'h0;
      free_at[g]   = n + init_len(g) + 1;
      buf_valid[g] = 1'b1;
      buf_tag[g]   = 30'h0;
      buf_word[g]  = mem[0];
    end
  endtask

  function automatic logic all_free();
    for (int g = 0; g < N_INST; g++) if (free_at[g] > cyc + 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_free();
    int guard;
    guard = 0;
    while (!all_free() && guard < 64) begin
      apply_stimulus(1'b0, addr);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_free_timeout cyc=%0d got=%0d exp=<64", cyc, guard);
    end
  endtask

  // Monitor: checks every instance shortly after each rising edge.
  initial begin
    exp_t        e;
    logic        eb;
    int unsigned k;
    forever begin
      @(posedge clk);
      #1;
      k = cyc;
      for (int g = 0; g < N_INST; g++) begin
        if (rst) begin
          exp_instr[g] = 16'h0;
          check_output("rst_busy", g, 32'(flash_busy[g]), 0);
          check_output("rst_mem_rd", g, 32'(mem_rd[g]), 0);
          check_output("rst_valid", g, 32'(instr_valid[g]), 0);
          check_output("rst_instr", g, 32'(instr[g]), 0);
          check_output("rst_mem_addr", g, mem_addr[g], 0);
        end else begin
          eb = (k >= win_lo[g]) && (k < win_hi[g]);
          check_output("busy", g, 32'(flash_busy[g]), 32'(eb));
          check_output("mem_rd", g, 32'(mem_rd[g]), 32'(eb));
          check_output("mem_addr", g, mem_addr[g], win_addr[g]);
          if (instr_valid[g]) begin
            if (exp_q[g].size() == 0) begin
              check_output("spurious_valid", g, 32'(instr_valid[g]), 0);
            end else begin
              e = exp_q[g].pop_front();
              check_output("valid_edge", g, k, e.edge_no);
              check_output("instr", g, 32'(instr[g]), 32'(e.half));
              exp_instr[g] = e.half;
            end
          end else begin
            if (exp_q[g].size() > 0 && exp_q[g][0].edge_no <= k) begin
              check_output("missing_valid", g, 32'(instr_valid[g]), 1);
              e = exp_q[g].pop_front();
              exp_instr[g] = e.half;
            end else begin
              check_output("instr_hold", g, 32'(instr[g]), 32'(exp_instr[g]));
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          guard;
    logic        pending;
    rst      = 1'b1;
    ld_flash = 1'b0;
    addr     = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[32'h100 >> 2] = 32'hBEEF_4770;
    @(negedge clk);
    $display("[TB] reset and init window");
    do_reset(3);

    $display("[TB] directed miss 0x100 then hit 0x102");
    wait_free();
    apply_stimulus(1'b1, 32'h100);
    wait_free();
    apply_stimulus(1'b1, 32'h102);
    apply_stimulus(1'b0, 32'h0);

    $display("[TB] strobe held for 3 cycles on a miss");
    wait_free();
    apply_stimulus(1'b1, 32'h200);
    apply_stimulus(1'b1, 32'h200);
    apply_stimulus(1'b1, 32'h200);
    apply_stimulus(1'b0, 32'h0);

    $display("[TB] back-to-back hits including odd addresses");
    wait_free();
    apply_stimulus(1'b1, 32'h200);
    apply_stimulus(1'b1, 32'h202);
    apply_stimulus(1'b1, 32'h201);
    apply_stimulus(1'b1, 32'h203);
    apply_stimulus(1'b0, 32'h0);

    $display("[TB] randomized strobes");
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_03FF) : 32'($urandom_range(0, 32'h3F));
      if ($urandom_range(0, 7) == 0) a[31:20] = 12'($urandom);
      apply_stimulus($urandom_range(0, 9) < 6, a);
    end

    $display("[TB] reset during access");
    wait_free();
    apply_stimulus(1'b1, 32'h300);
    do_reset(2);
    wait_free();
    apply_stimulus(1'b1, 32'h102);
    apply_stimulus(1'b0, 32'h0);

    guard   = 0;
    pending = 1'b1;
    while (pending && guard < 64) begin
      pending = 1'b0;
      for (int g = 0; g < N_INST; g++)
        if (exp_q[g].size() != 0 || cyc <= win_hi[g]) pending = 1'b1;
      if (pending) apply_stimulus(1'b0, 32'h0);
      guard++;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < N_INST; g++) check_output("queue_drained", g, exp_q[g].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
